// File: rtl/upe_serial_rx.sv
// ============================================================================
// Module   : upe_serial_rx
// Brief    : LSB-first 32-bit serial word receiver with valid/ready output.
//            Optional 2-of-3 majority bit sampling when UPE_RX_MAJORITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module upe_serial_rx #(
  parameter int BIT_PERIOD = 1251,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        start,
  input  logic        ready,
  output logic [15:0] Out1,
  output logic [15:0] Out2,
  output logic        valid,
  output logic        overrun,
  output logic        busy
);

  localparam int CW = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0] c_LAST = CW'(BIT_PERIOD - 1);
`ifdef UPE_RX_MAJORITY_EN
  localparam logic [CW-1:0] c_MIDM1  = CW'(BIT_PERIOD / 2 - 1);
  localparam logic [CW-1:0] c_MID    = CW'(BIT_PERIOD / 2);
  localparam logic [CW-1:0] c_SAMPLE = CW'(BIT_PERIOD / 2 + 1);
`else
  localparam logic [CW-1:0] c_SAMPLE = CW'(BIT_PERIOD / 2);
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_sync;
  logic           w_din_s;
  logic [CW-1:0]  r_cnt;
  logic [4:0]     r_bitnum;
  logic [30:0]    r_shreg;
  logic           w_sample;
  logic           w_done;
  logic           w_bit;

  assign w_din_s  = r_sync[1];
  assign w_sample = (r_state == S_RECV) && !start && (r_cnt == c_SAMPLE);
  assign w_done   = w_sample && (r_bitnum == 5'd31);
  assign busy     = (r_state != S_IDLE);

`ifdef UPE_RX_MAJORITY_EN
  logic r_s0;
  logic r_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else if (r_state == S_RECV) begin
      if (r_cnt == c_MIDM1) r_s0 <= w_din_s;
      if (r_cnt == c_MID)   r_s1 <= w_din_s;
    end
  end

  assign w_bit = (r_s0 & r_s1) | (r_s0 & w_din_s) | (r_s1 & w_din_s);
`else
  assign w_bit = w_din_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_sync <= 2'b00;
    else     r_sync <= {r_sync[0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RECV;
      S_RECV: begin
        if (start)
          w_state_nxt = S_RECV;
        else if (!CONTINUOUS && (r_cnt == c_LAST) && (r_bitnum == 5'd31))
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit 31 bypasses the shift register straight into the output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_bitnum <= 5'd0;
      r_shreg  <= '0;
    end else if (start) begin
      r_cnt    <= '0;
      r_bitnum <= 5'd0;
    end else if (r_state == S_RECV) begin
      if (w_sample && (r_bitnum != 5'd31)) r_shreg[r_bitnum] <= w_bit;
      if (r_cnt == c_LAST) begin
        r_cnt    <= '0;
        r_bitnum <= r_bitnum + 5'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Out1    <= 16'h0000;
      Out2    <= 16'h0000;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (w_done) begin
        {Out1, Out2} <= {w_bit, r_shreg};
        valid        <= 1'b1;
        if (valid && !ready) overrun <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_upe_serial_rx.sv
// ============================================================================
// Module   : tb_upe_serial_rx
// Brief    : Self-checking bench for upe_serial_rx (continuous and one-shot).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_upe_serial_rx;

  localparam int BP  = 8;
  localparam int MID = BP / 2;
  localparam int WORD_CYC = 32 * BP;
`ifdef UPE_RX_MAJORITY_EN
  localparam int LAT = 31 * BP + MID + 3;
`else
  localparam int LAT = 31 * BP + MID + 2;
`endif

  logic clk = 1'b0;
  logic rst, din, start, ready;
  logic [15:0] o1c, o2c, o1s, o2s;
  logic vc, ovc, bc, vs, ovs, bs;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    int          t;
    logic [31:0] w;
    logic        ov;
  } ev_t;
  ev_t  evq[$];
  logic pv = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  upe_serial_rx #(.BIT_PERIOD(BP), .CONTINUOUS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .din(din), .start(start), .ready(ready),
    .Out1(o1c), .Out2(o2c), .valid(vc), .overrun(ovc), .busy(bc)
  );

  upe_serial_rx #(.BIT_PERIOD(BP), .CONTINUOUS(1'b0)) dut_s (
    .clk(clk), .rst(rst), .din(din), .start(start), .ready(ready),
    .Out1(o1s), .Out2(o2s), .valid(vs), .overrun(ovs), .busy(bs)
  );

  // Log every rising edge of the continuous receiver's valid.
  always @(negedge clk) begin
    if (vc && !pv) evq.push_back('{cyc, {o1c, o2c}, ovc});
    pv = vc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the line as a transmitter would: bit k occupies cycles k*BP..k*BP+BP-1.
  task automatic send(input logic [31:0] w, input int ncyc, input bit with_start,
                      input bit glitch, output int t0);
    t0 = cyc;
    for (int i = 0; i < ncyc; i++) begin
      start = with_start && (i == 0);
      din   = w[i / BP] ^ (glitch && ((i % BP) == MID));
      tick();
    end
    start = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_events(input string name, input int t0, input logic [31:0] exp_w[$]);
    nvec++;
    if (evq.size() !== exp_w.size()) begin
      nerr++;
      $display("FAIL %s valid-count: got %0d want %0d", name, evq.size(), exp_w.size());
    end
    for (int k = 0; k < exp_w.size() && k < evq.size(); k++) begin
      nvec++;
      if (evq[k].t - t0 !== LAT + k * WORD_CYC) begin
        nerr++;
        $display("FAIL %s valid-cycle[%0d]: got %0d want %0d", name, k, evq[k].t - t0, LAT + k * WORD_CYC);
      end
      nvec++;
      if (evq[k].w !== exp_w[k]) begin
        nerr++;
        $display("FAIL %s word[%0d]: got %h want %h", name, k, evq[k].w, exp_w[k]);
      end
      nvec++;
      if (evq[k].ov !== 1'b0) begin
        nerr++;
        $display("FAIL %s overrun[%0d]: got %b want 0", name, k, evq[k].ov);
      end
    end
  endtask

  task automatic check_zero(input string name);
    nvec++;
    if ({o1c, o2c, vc, ovc, bc} !== 35'd0) begin
      nerr++;
      $display("FAIL %s cont-outputs: got %h/%h v%b o%b b%b want all 0", name, o1c, o2c, vc, ovc, bc);
    end
    nvec++;
    if ({o1s, o2s, vs, ovs, bs} !== 35'd0) begin
      nerr++;
      $display("FAIL %s single-outputs: got %h/%h v%b o%b b%b want all 0", name, o1s, o2s, vs, ovs, bs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_zero("reset");
  endtask

  task automatic test_basic();
    int t0;
    logic [31:0] exp_w[$];
    evq.delete();
    ready = 1'b1;
    send(32'h34D51531, WORD_CYC, 1'b1, 1'b0, t0);
    exp_w.push_back(32'h34D51531);
    check_events("basic", t0, exp_w);
    nvec++;
    if (vc !== 1'b0) begin nerr++; $display("FAIL basic valid-drop: got %b want 0", vc); end
    nvec++;
    if ({o1s, o2s} !== 32'h34D51531) begin
      nerr++;
      $display("FAIL basic single-word: got %h want 34d51531", {o1s, o2s});
    end
    nvec++;
    if (bs !== 1'b1) begin nerr++; $display("FAIL basic single-busy-last: got %b want 1", bs); end
    tick();
    nvec++;
    if (bs !== 1'b0) begin nerr++; $display("FAIL basic single-idle: got %b want 0", bs); end
    nvec++;
    if (bc !== 1'b1) begin nerr++; $display("FAIL basic cont-busy: got %b want 1", bc); end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    logic [31:0] exp_w[$];
    pulse_rst();
    evq.delete();
    send(32'hCB2BEACF, WORD_CYC, 1'b1, 1'b0, t0);
    send(32'h00000000, WORD_CYC, 1'b0, 1'b0, t1);
    exp_w.push_back(32'hCB2BEACF);
    exp_w.push_back(32'h00000000);
    check_events("b2b", t0, exp_w);
  endtask

  task automatic test_overrun();
    int t0;
    pulse_rst();
    ready = 1'b0;
    send(32'hFFFF0000, WORD_CYC, 1'b1, 1'b0, t0);
    send(32'h0000FFFF, WORD_CYC, 1'b0, 1'b0, t0);
    nvec++;
    if ({o1c, o2c, vc, ovc} !== {32'h0000FFFF, 1'b1, 1'b1}) begin
      nerr++;
      $display("FAIL overrun state: got %h/%h v%b o%b want 0000/ffff v1 o1", o1c, o2c, vc, ovc);
    end
    nvec++;
    if ({o1s, o2s, vs, ovs} !== {32'hFFFF0000, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL overrun single: got %h/%h v%b o%b want ffff/0000 v1 o0", o1s, o2s, vs, ovs);
    end
    ready = 1'b1;
    tick();
    nvec++;
    if ({vc, ovc} !== 2'b01) begin
      nerr++;
      $display("FAIL overrun accept: got v%b o%b want v0 o1", vc, ovc);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [31:0] exp_w[$];
    send(32'hDEADBEEF, 17 * BP + 3, 1'b1, 1'b0, t0);
    pulse_rst();
    check_zero("rst-mid");
    evq.delete();
    send(32'hA5A5A5A5, WORD_CYC, 1'b1, 1'b0, t0);
    exp_w.push_back(32'hA5A5A5A5);
    check_events("rst-mid", t0, exp_w);
    nvec++;
    if (ovc !== 1'b0) begin nerr++; $display("FAIL rst-mid overrun: got %b want 0", ovc); end
  endtask

  task automatic test_restart();
    int t0, tx;
    logic [31:0] exp_w[$];
    evq.delete();
    send(32'hDEADBEEF, 10 * BP + 3, 1'b1, 1'b0, tx);
    send(32'h12345678, WORD_CYC, 1'b1, 1'b0, t0);
    exp_w.push_back(32'h12345678);
    check_events("restart", t0, exp_w);
    nvec++;
    if ({o1s, o2s} !== 32'h12345678) begin
      nerr++;
      $display("FAIL restart single-word: got %h want 12345678", {o1s, o2s});
    end
  endtask

  task automatic test_random();
    int t0, tx;
    logic [31:0] exp_w[$];
    pulse_rst();
    evq.delete();
    for (int k = 0; k < 6; k++) exp_w.push_back($urandom);
    send(exp_w[0], WORD_CYC, 1'b1, 1'b0, t0);
    for (int k = 1; k < 6; k++) send(exp_w[k], WORD_CYC, 1'b0, 1'b0, tx);
    check_events("random", t0, exp_w);
  endtask

`ifdef UPE_RX_MAJORITY_EN
  task automatic test_glitch();
    int t0;
    logic [31:0] exp_w[$];
    pulse_rst();
    evq.delete();
    send(32'h0F0F0F0F, WORD_CYC, 1'b1, 1'b1, t0);
    exp_w.push_back(32'h0F0F0F0F);
    check_events("glitch", t0, exp_w);
  endtask
`endif

  initial begin
    rst   = 1'b1;
    din   = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_restart();
    test_random();
`ifdef UPE_RX_MAJORITY_EN
    test_glitch();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
